qla_agent: RTL and testbench
============================

Name: qla_agent

Overview:
- Episode controller and environment model that drives the Q-learning datapath (qla datapath = RAM bank + maxQ + Q_updater).
- Generates current_state, next_state, act, step and decoder_en each cycle.
- Reads back the four Q values of next_state to make epsilon-greedy action choices.
- Walks a 5x5 grid (states 1..25, start 1, goal 25) for N_EPISODES episodes, then asserts done.

Parameters:
- N_EPISODES, 100: episodes to run before done.
- EPSILON, 26: explore threshold out of 256 (~0.1). 0 means pure greedy.
- LFSR_SEED, 16'hACE1: reset value of the exploration LFSR. Must be nonzero.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin training. Sampled only in IDLE.
- Qnext_0..Qnext_3  in  32 each  signed Q(next_state, a) from the datapath, combinational read.
- current_state  out  5  write address of the datapath.
- next_state  out  5  read address; also the reward input.
- act  out  2  action: 0=up, 1=right, 2=down, 3=left.
- step  out  4  transition index within the episode.
- decoder_en  out  1  Q write strobe.
- episode  out  16  completed-episode count.
- busy  out  1  high in any state other than IDLE and DONE.
- done  out  1  high in DONE, held until rst.

Behaviour:
- Reset: on rst at a clk edge (synchronous, active-high):
  - FSM goes to IDLE.
  - current_state=1, step=0, episode=0, act=0, decoder_en=0, busy=0, done=0.
  - next_state=1.
  - LFSR=LFSR_SEED, greedy_act=0.
  - Reset mid-episode aborts immediately; Q RAM contents are not the agent's concern.
- Grid geometry:
  - state s = 5*row + col + 1, row/col in 0..4. Keep row/col registers; no divider.
  - up = row-1, right = col+1, down = row+1, left = col-1.
  - A move off the grid leaves the state unchanged.
- Terminal states: 25 (goal) and demons {5,7,8,14,17,19,20,22}.
- Greedy choice (argmax):
  - Signed 32-bit compare of Qnext_0..3.
  - Ties resolve to the lowest index.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every cycle when not in reset.
  - explore = (lfsr[15:8] < EPSILON). When exploring, act = lfsr[1:0].
- IDLE:
  - All strobes low; next_state=current_state=1.
  - start=1 moves to PRIME.
- PRIME (1 cycle):
  - next_state=current_state, decoder_en=0.
  - The datapath delay registers capture Q(current,*).
  - greedy_act <= argmax(Qnext_*).
  - Move to UPDATE.
- UPDATE (one transition per cycle):
  - act = explore ? lfsr[1:0] : greedy_act.
  - next_state = move(current_state, act), combinational from registered row/col and act.
  - decoder_en=1; step = transitions already taken this episode.
  - At the clock edge:
    - greedy_act <= argmax(Qnext_*), which are now the Q values of next_state.
    - current_state/row/col <= next_state.
    - step <= step+1.
  - Exit to EP_END if next_state is terminal OR step==15. The 16th transition carries step=15 so the datapath applies -50. Both conditions together: still a single exit.
  - Otherwise stay in UPDATE.
- EP_END (1 cycle):
  - decoder_en=0.
  - current_state <= 1, step <= 0, episode <= episode+1.
  - If episode+1 == N_EPISODES go to DONE, else go to PRIME.
- DONE:
  - done=1, busy=0.
  - start is ignored; only rst leaves DONE.
- start asserted outside IDLE: ignored.
- decoder_en is never high outside UPDATE.

Decomposition:
- Shared package qla_pkg holds:
  - GRID_DIM=5, START_STATE=1, GOAL_STATE=25.
  - Demon-state list and is_terminal function.
  - Action encodings ACT_UP/RIGHT/DOWN/LEFT.
  - FSM state enum.
- Combinational sub-module qla_argmax4: four signed 32-bit inputs, 2-bit index output, lowest index wins ties. Reusable by the datapath.

Test Plan:
- Reset values: assert rst for 2 cycles mid-UPDATE -> all outputs at reset values next cycle; busy=0; no decoder_en pulse.
- Timeout, pure greedy (EPSILON=0, bench returns Qnext all 0):
  - act=0 always; state 1 hits the top wall, so next_state=1 every cycle.
  - Exactly 16 decoder_en pulses with step 0..15, then EP_END; episode becomes 1; PRIME follows.
- Demon termination (EPSILON=0, bench makes Qnext_1=10 and others 0):
  - next_state sequence 2,3,4,5.
  - 4 decoder_en pulses; episode ends because 5 is a demon.
- Wall and path (EPSILON=0; Qnext_2 max for 4 transitions, then Qnext_3 max):
  - next_state 6,11,16,21, then 21 again (left wall); current_state stays 21.
- Argmax ties and negatives:
  - Qnext = {-5,-5,-10,-20} -> act=0.
  - Qnext = {-1,3,3,0} -> act=1.
  - Qnext = {0x80000000,-1,-2,-3} -> act=1.
- Completion (N_EPISODES=2, EPSILON=0, all-zero Q):
  - done rises after the second EP_END; episode=2.
  - A start pulse while busy or done has no effect.

Source files
------------

// File: rtl/qla_pkg.sv
// Shared definitions for the Q-learning agent: grid geometry, terminal states,
// action encodings and the episode-controller state enum.
package qla_pkg;

    localparam int         GRID_DIM    = 5;
    localparam logic [4:0] START_STATE = 5'd1;
    localparam logic [4:0] GOAL_STATE  = 5'd25;

    localparam int N_DEMONS = 8;
    localparam logic [N_DEMONS-1:0][4:0] DEMON_LIST = {
        5'd5, 5'd7, 5'd8, 5'd14, 5'd17, 5'd19, 5'd20, 5'd22
    };

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_RIGHT = 2'd1;
    localparam logic [1:0] ACT_DOWN  = 2'd2;
    localparam logic [1:0] ACT_LEFT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRIME  = 3'd1,
        ST_UPDATE = 3'd2,
        ST_EP_END = 3'd3,
        ST_DONE   = 3'd4
    } agent_state_e;

    // An episode ends on reaching the goal or stepping onto any demon.
    function automatic logic is_terminal(input logic [4:0] s);
        logic hit;
        hit = (s == GOAL_STATE);
        for (int i = 0; i < N_DEMONS; i++) begin
            if (s == DEMON_LIST[i]) begin
                hit = 1'b1;
            end else begin
                hit = hit;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/qla_argmax4.sv
// Index of the largest of four signed 32-bit values; the lowest index wins ties.
module qla_argmax4 (
    input  logic signed [31:0] q0_i,
    input  logic signed [31:0] q1_i,
    input  logic signed [31:0] q2_i,
    input  logic signed [31:0] q3_i,
    output logic        [1:0]  idx_o
);

    logic signed [31:0] v01_s;
    logic signed [31:0] v23_s;
    logic        [1:0]  i01_s;
    logic        [1:0]  i23_s;

    // Pairwise tree; strict greater-than keeps the lower index on equality.
    always_comb begin
        v01_s = q0_i;
        i01_s = 2'd0;
        v23_s = q2_i;
        i23_s = 2'd2;
        idx_o = 2'd0;
        if (q1_i > q0_i) begin
            v01_s = q1_i;
            i01_s = 2'd1;
        end else begin
            v01_s = q0_i;
            i01_s = 2'd0;
        end
        if (q3_i > q2_i) begin
            v23_s = q3_i;
            i23_s = 2'd3;
        end else begin
            v23_s = q2_i;
            i23_s = 2'd2;
        end
        if (v23_s > v01_s) begin
            idx_o = i23_s;
        end else begin
            idx_o = i01_s;
        end
    end

endmodule

// File: rtl/qla_agent.sv
// Episode controller and 5x5 grid environment driving the Q-learning datapath
// with epsilon-greedy actions.
module qla_agent
    import qla_pkg::*;
#(
    parameter int unsigned N_EPISODES = 100,
    parameter int unsigned EPSILON    = 26,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic signed [31:0] Qnext_0,
    input  logic signed [31:0] Qnext_1,
    input  logic signed [31:0] Qnext_2,
    input  logic signed [31:0] Qnext_3,
    output logic        [4:0]  current_state,
    output logic        [4:0]  next_state,
    output logic        [1:0]  act,
    output logic        [3:0]  step,
    output logic               decoder_en,
    output logic        [15:0] episode,
    output logic               busy,
    output logic               done
);

    localparam logic [8:0]  EPS_C    = 9'(EPSILON);
    localparam logic [15:0] N_EP_C   = 16'(N_EPISODES);
    localparam logic [2:0]  EDGE_C   = 3'(GRID_DIM - 1);
    localparam logic [3:0]  LAST_STEP = 4'd15;

    agent_state_e state_q, state_d;
    logic [2:0]   row_q, row_d, col_q, col_d;
    logic [4:0]   cur_q, cur_d;
    logic [3:0]   step_q, step_d;
    logic [15:0]  episode_q, episode_d;
    logic [15:0]  lfsr_q, lfsr_d;
    logic [1:0]   greedy_q, greedy_d;

    logic [1:0]   argmax_s;
    logic [1:0]   act_s;
    logic         explore_s;
    logic [2:0]   nrow_s, ncol_s;
    logic [4:0]   nstate_s;
    logic [15:0]  ep_inc_s;

    qla_argmax4 u_argmax (
        .q0_i  (Qnext_0),
        .q1_i  (Qnext_1),
        .q2_i  (Qnext_2),
        .q3_i  (Qnext_3),
        .idx_o (argmax_s)
    );

    // Action selection and grid move; off-grid moves leave row/col unchanged.
    always_comb begin
        explore_s = ({1'b0, lfsr_q[15:8]} < EPS_C);
        act_s     = ACT_UP;
        nrow_s    = row_q;
        ncol_s    = col_q;
        if (state_q == ST_UPDATE) begin
            act_s = explore_s ? lfsr_q[1:0] : greedy_q;
        end else begin
            act_s = ACT_UP;
        end
        case (act_s)
            ACT_UP:    nrow_s = (row_q != 3'd0)   ? row_q - 3'd1 : row_q;
            ACT_RIGHT: ncol_s = (col_q != EDGE_C) ? col_q + 3'd1 : col_q;
            ACT_DOWN:  nrow_s = (row_q != EDGE_C) ? row_q + 3'd1 : row_q;
            ACT_LEFT:  ncol_s = (col_q != 3'd0)   ? col_q - 3'd1 : col_q;
            default: begin
                nrow_s = row_q;
                ncol_s = col_q;
            end
        endcase
        // s = 5*row + col + 1 without a multiplier
        nstate_s = {nrow_s, 2'b00} + {2'b00, nrow_s} + {2'b00, ncol_s} + 5'd1;
    end

    // Next-state logic for the episode FSM and its datapath registers.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cur_d     = cur_q;
        step_d    = step_q;
        episode_d = episode_q;
        greedy_d  = greedy_q;
        lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        ep_inc_s  = episode_q + 16'd1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRIME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                greedy_d = argmax_s;
                state_d  = ST_UPDATE;
            end
            ST_UPDATE: begin
                // Qnext now reflects next_state, so this argmax drives the following move
                greedy_d = argmax_s;
                cur_d    = nstate_s;
                row_d    = nrow_s;
                col_d    = ncol_s;
                step_d   = step_q + 4'd1;
                if (is_terminal(nstate_s) || (step_q == LAST_STEP)) begin
                    state_d = ST_EP_END;
                end else begin
                    state_d = ST_UPDATE;
                end
            end
            ST_EP_END: begin
                cur_d     = START_STATE;
                row_d     = 3'd0;
                col_d     = 3'd0;
                step_d    = 4'd0;
                episode_d = ep_inc_s;
                if (ep_inc_s == N_EP_C) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_PRIME;
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            cur_q     <= START_STATE;
            step_q    <= 4'd0;
            episode_q <= 16'd0;
            lfsr_q    <= LFSR_SEED;
            greedy_q  <= ACT_UP;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            cur_q     <= cur_d;
            step_q    <= step_d;
            episode_q <= episode_d;
            lfsr_q    <= lfsr_d;
            greedy_q  <= greedy_d;
        end
    end

    assign current_state = cur_q;
    assign next_state    = (state_q == ST_UPDATE) ? nstate_s : cur_q;
    assign act           = act_s;
    assign step          = step_q;
    assign decoder_en    = (state_q == ST_UPDATE);
    assign episode       = episode_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_qla_agent.sv
// Directed and randomized checks of qla_agent against a grid-walk reference model.
module tb_qla_agent;

    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          EPS_B = 64;
    localparam int          NEP_B = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: pure greedy, two episodes (directed tests)
    logic               start_a;
    logic signed [31:0] qa0, qa1, qa2, qa3;
    logic [4:0]  cs_a, ns_a;
    logic [1:0]  act_a;
    logic [3:0]  step_a;
    logic        dec_a, busy_a, done_a;
    logic [15:0] ep_a;

    // Instance B: exploring, randomized Q values
    logic               start_b;
    logic signed [31:0] qb0, qb1, qb2, qb3;
    logic [4:0]  cs_b, ns_b;
    logic [1:0]  act_b;
    logic [3:0]  step_b;
    logic        dec_b, busy_b, done_b;
    logic [15:0] ep_b;

    qla_agent #(.N_EPISODES(2), .EPSILON(0), .LFSR_SEED(SEED)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .Qnext_0(qa0), .Qnext_1(qa1), .Qnext_2(qa2), .Qnext_3(qa3),
        .current_state(cs_a), .next_state(ns_a), .act(act_a), .step(step_a),
        .decoder_en(dec_a), .episode(ep_a), .busy(busy_a), .done(done_a)
    );

    qla_agent #(.N_EPISODES(NEP_B), .EPSILON(EPS_B), .LFSR_SEED(SEED)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .Qnext_0(qb0), .Qnext_1(qb1), .Qnext_2(qb2), .Qnext_3(qb3),
        .current_state(cs_b), .next_state(ns_b), .act(act_b), .step(step_b),
        .decoder_en(dec_b), .episode(ep_b), .busy(busy_b), .done(done_b)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [15:0] m_lfsr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; the model LFSR follows the reset/advance rule at the same edge.
    task automatic tick();
        @(posedge clk);
        if (rst) m_lfsr = SEED;
        else     m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        @(negedge clk);
    endtask

    function automatic int ref_argmax(input int q[4]);
        int best = 0;
        for (int i = 1; i < 4; i++) if (q[i] > q[best]) best = i;
        return best;
    endfunction

    function automatic int ref_move(input int s, input int a);
        int r = (s - 1) / 5;
        int c = (s - 1) % 5;
        case (a)
            0: if (r > 0) r--;
            1: if (c < 4) c++;
            2: if (r < 4) r++;
            3: if (c > 0) c--;
            default: ;
        endcase
        return 5 * r + c + 1;
    endfunction

    function automatic bit ref_term(input int s);
        return s inside {5, 7, 8, 14, 17, 19, 20, 22, 25};
    endfunction

    function automatic int rnd_q();
        case ($urandom_range(0, 3))
            0:       return 0;
            1:       return int'($urandom_range(0, 4)) - 2;
            default: return int'($urandom);
        endcase
    endfunction

    task automatic set_qa(input int a0, input int a1, input int a2, input int a3);
        qa0 = a0; qa1 = a1; qa2 = a2; qa3 = a3;
    endtask

    task automatic chk_reset_a(input string tag);
        chk({tag, "_cs"},   cs_a,   1);
        chk({tag, "_ns"},   ns_a,   1);
        chk({tag, "_step"}, step_a, 0);
        chk({tag, "_ep"},   ep_a,   0);
        chk({tag, "_act"},  act_a,  0);
        chk({tag, "_dec"},  dec_a,  0);
        chk({tag, "_busy"}, busy_a, 0);
        chk({tag, "_done"}, done_a, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int qtab[9][4];
        int acts[9];
        int nss[9];
        int q[4];
        int cur, greedy, ea, ens;
        bit explore;

        qtab = '{'{0, 0, 5, 0}, '{0, 0, 5, 0}, '{0, 0, 5, 0}, '{0, 0, 5, 0},
                 '{0, 0, 0, 5}, '{-5, -5, -10, -20}, '{-5, -5, -10, -20},
                 '{-1, 3, 3, 0}, '{int'(32'h8000_0000), -1, -2, -3}};
        acts = '{2, 2, 2, 2, 3, 0, 0, 1, 1};
        nss  = '{6, 11, 16, 21, 21, 16, 11, 12, 13};

        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        set_qa(0, 0, 0, 0);
        qb0 = 0; qb1 = 0; qb2 = 0; qb3 = 0;
        tick(); tick();
        chk_reset_a("reset");
        chk("reset_busy_b", busy_b, 0);
        rst = 1'b0;

        // Timeout episode: all-zero Q, greedy up into the top wall
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("to_prime_busy", busy_a, 1);
        chk("to_prime_dec",  dec_a,  0);
        tick();
        for (int k = 0; k < 16; k++) begin
            chk("to_dec",  dec_a,  1);
            chk("to_step", step_a, k);
            chk("to_act",  act_a,  0);
            chk("to_ns",   ns_a,   1);
            start_a = (k == 5);
            tick();
        end
        start_a = 1'b0;
        chk("to_epend_dec",  dec_a,  0);
        chk("to_epend_busy", busy_a, 1);
        chk("to_epend_ep",   ep_a,   0);
        tick();
        chk("to_prime2_ep",   ep_a,   1);
        chk("to_prime2_dec",  dec_a,  0);
        chk("to_prime2_step", step_a, 0);
        chk("to_prime2_busy", busy_a, 1);

        // Demon episode: right along the top row into state 5
        set_qa(0, 10, 0, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("dm_dec",  dec_a,  1);
            chk("dm_act",  act_a,  1);
            chk("dm_cs",   cs_a,   k + 1);
            chk("dm_ns",   ns_a,   k + 2);
            chk("dm_step", step_a, k);
            tick();
        end
        chk("dm_epend_dec", dec_a, 0);
        chk("dm_epend_cs",  cs_a,  5);
        tick();
        chk("cmp_done", done_a, 1);
        chk("cmp_busy", busy_a, 0);
        chk("cmp_ep",   ep_a,   2);
        start_a = 1'b1; tick(); start_a = 1'b0; tick();
        chk("cmp_hold_done", done_a, 1);
        chk("cmp_hold_busy", busy_a, 0);
        chk("cmp_hold_dec",  dec_a,  0);
        chk("cmp_hold_ep",   ep_a,   2);

        // Wall/path plus argmax ties and negative values
        rst = 1'b1; tick(); rst = 1'b0;
        chk_reset_a("rst2");
        set_qa(qtab[0][0], qtab[0][1], qtab[0][2], qtab[0][3]);
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        for (int k = 0; k < 9; k++) begin
            chk("wp_dec",  dec_a,  1);
            chk("wp_step", step_a, k);
            chk("wp_act",  act_a,  acts[k]);
            chk("wp_ns",   ns_a,   nss[k]);
            chk("wp_cs",   cs_a,   (k == 0) ? 1 : nss[k-1]);
            if (k < 8) set_qa(qtab[k+1][0], qtab[k+1][1], qtab[k+1][2], qtab[k+1][3]);
            tick();
        end

        // Reset held two cycles in the middle of UPDATE
        chk("mid_dec_before", dec_a, 1);
        rst = 1'b1; tick();
        chk("mid_rst_dec",  dec_a,  0);
        chk("mid_rst_busy", busy_a, 0);
        tick(); rst = 1'b0;
        chk_reset_a("mid_rst");
        tick();
        chk("mid_idle_dec",  dec_a,  0);
        chk("mid_idle_busy", busy_a, 0);

        // Randomized epsilon-greedy episodes on instance B
        start_b = 1'b1; tick(); start_b = 1'b0;
        cur = 1;
        for (int ep = 0; ep < NEP_B; ep++) begin
            chk("rnd_prime_busy", busy_b, 1);
            chk("rnd_prime_dec",  dec_b,  0);
            chk("rnd_prime_cs",   cs_b,   1);
            chk("rnd_prime_ep",   ep_b,   ep);
            for (int i = 0; i < 4; i++) q[i] = rnd_q();
            qb0 = q[0]; qb1 = q[1]; qb2 = q[2]; qb3 = q[3];
            greedy = ref_argmax(q);
            tick();
            for (int k = 0; k < 16; k++) begin
                explore = (int'(m_lfsr[15:8]) < EPS_B);
                ea  = explore ? int'(m_lfsr[1:0]) : greedy;
                ens = ref_move(cur, ea);
                chk("rnd_dec",  dec_b,  1);
                chk("rnd_step", step_b, k);
                chk("rnd_act",  act_b,  ea);
                chk("rnd_ns",   ns_b,   ens);
                chk("rnd_cs",   cs_b,   cur);
                for (int i = 0; i < 4; i++) q[i] = rnd_q();
                qb0 = q[0]; qb1 = q[1]; qb2 = q[2]; qb3 = q[3];
                greedy = ref_argmax(q);
                tick();
                cur = ens;
                if (ref_term(ens)) break;
            end
            chk("rnd_epend_dec",  dec_b,  0);
            chk("rnd_epend_busy", busy_b, 1);
            tick();
            cur = 1;
        end
        chk("rnd_done", done_b, 1);
        chk("rnd_ep",   ep_b,   NEP_B);
        chk("rnd_busy", busy_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
